// File: rtl/ring_counter.sv
// ring_counter: one-hot ring counter with binary hot-bit index, wrap pulse and one-hot error flag.
// Optional RING_SELF_CORRECT_EN: flag non-one-hot q and reload SEED on the next edge.
module ring_counter #(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
    parameter bit              DIR_LEFT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     wrap,
    output logic                     err
);
    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    function automatic logic [PW-1:0] idx(input logic [WIDTH-1:0] v);
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) idx = PW'(i);
    endfunction

    localparam logic [PW-1:0] SEED_POS = idx(SEED);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("ring_counter: WIDTH must be in 2..32");
    end
    if (SEED == '0 || (SEED & (SEED - 1'b1)) != '0) begin : g_bad_seed
        $error("ring_counter: SEED must be one-hot");
    end

    logic [WIDTH-1:0] rot, q_nxt;
    logic [PW-1:0]    pos_rot, pos_nxt;
    logic             wrap_nxt;

    always_comb begin
        rot     = DIR_LEFT ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
        pos_rot = DIR_LEFT ? ((pos == LAST) ? '0 : pos + PW'(1))
                           : ((pos == '0) ? LAST : pos - PW'(1));
`ifdef RING_SELF_CORRECT_EN
        err      = $countones(q) != 1;
        q_nxt    = err ? SEED : rot;
        pos_nxt  = err ? SEED_POS : pos_rot;
        wrap_nxt = !err && rot == SEED;
`else
        err      = 1'b0;
        q_nxt    = rot;
        pos_nxt  = pos_rot;
        wrap_nxt = rot == SEED;
`endif
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            q    <= SEED;
            pos  <= SEED_POS;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            pos  <= pos_nxt;
            wrap <= wrap_nxt;
        end
endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter: scoreboard bench for ring_counter in left, right and 8-bit configurations.
module tb_ring_counter;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] lq, rq;
    logic [7:0] wq;
    logic [1:0] lpos, rpos;
    logic [2:0] wpos;
    logic lwrap, rwrap, wwrap, lerr, rerr, werr;
    int total = 0, bad = 0, k = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [2:0] pos;
        logic       wrap;
        logic       err;
    } exp_t;
    typedef struct {
        exp_t l, r, w;
    } ent_t;
    ent_t sb[$];

    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR_LEFT(1'b1)) dut_l (
        .clk(clk), .reset(reset), .q(lq), .pos(lpos), .wrap(lwrap), .err(lerr));
    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR_LEFT(1'b0)) dut_r (
        .clk(clk), .reset(reset), .q(rq), .pos(rpos), .wrap(rwrap), .err(rerr));
    ring_counter #(.WIDTH(8), .SEED(8'h01), .DIR_LEFT(1'b1)) dut_w (
        .clk(clk), .reset(reset), .q(wq), .pos(wpos), .wrap(wwrap), .err(werr));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected state after k rotations from SEED=1.
    function automatic exp_t mdl(input int w, input bit left, input int n);
        int s = n % w;
        int p = left ? s : (w - s) % w;
        mdl.q    = 8'(1) << p;
        mdl.pos  = 3'(p);
        mdl.wrap = n > 0 && s == 0;
        mdl.err  = 1'b0;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] q, input logic [2:0] pos,
                       input logic wrap, input logic err);
        check({tag, "_q"}, 32'(q), 32'(e.q));
        check({tag, "_pos"}, 32'(pos), 32'(e.pos));
        check({tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
        check({tag, "_err"}, 32'(err), 32'(e.err));
    endtask

    task automatic step();
        ent_t e;
        sb.push_back('{mdl(4, 1'b1, k + 1), mdl(4, 1'b0, k + 1), mdl(8, 1'b1, k + 1)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp("left", e.l, 8'(lq), 3'(lpos), lwrap, lerr);
        cmp("right", e.r, 8'(rq), 3'(rpos), rwrap, rerr);
        cmp("w8", e.w, wq, wpos, wwrap, werr);
        k++;
    endtask

    task automatic chk_seed(input string tag);
        cmp({tag, "_l"}, mdl(4, 1'b1, 0), 8'(lq), 3'(lpos), lwrap, lerr);
        cmp({tag, "_r"}, mdl(4, 1'b0, 0), 8'(rq), 3'(rpos), rwrap, rerr);
        cmp({tag, "_w"}, mdl(8, 1'b1, 0), wq, wpos, wwrap, werr);
    endtask

    initial begin
        for (int i = 0; i < 14; i++) begin
            #7;
            chk_seed("rst_hold");
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 18; i++) step();
        while (k % 4 != 2) step();
        @(negedge clk);
        #2;
        check("pre_async_q", 32'(lq), 32'h4);
        reset = 1'b1;
        #1;
        chk_seed("async_rst");
        @(negedge clk);
        chk_seed("async_hold");
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        force dut_l.q = 4'b0110;
        #1;
        release dut_l.q;
        #1;
`ifdef RING_SELF_CORRECT_EN
        check("force_err", 32'(lerr), 32'h1);
        @(posedge clk);
        #1;
        check("recover_q", 32'(lq), 32'h1);
        check("recover_pos", 32'(lpos), 32'h0);
        check("recover_wrap", 32'(lwrap), 32'h0);
        check("recover_err", 32'(lerr), 32'h0);
`else
        check("force_err", 32'(lerr), 32'h0);
        @(posedge clk);
        #1;
        check("illegal_q", 32'(lq), 32'hc);
        check("illegal_pos", 32'(lpos), 32'h2);
        check("illegal_err", 32'(lerr), 32'h0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
